// File: rtl/jtag_ssram_pkg.sv
// Shared definitions for the SSRAM port arbiter: parameter defaults and FSM encoding.
package jtag_ssram_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 9;
    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_BURST_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } arbState_t;

endpackage

// File: rtl/ssram_rr_arbiter.sv
// Two-requester round-robin grant with a pointer to the requester preferred on the next tie.
module ssram_rr_arbiter (
    input  logic       clock,
    input  logic       nReset,
    input  logic [1:0] request,
    input  logic       enable,
    output logic       grantValid,
    output logic       grantIndex
);

    logic preferred;

    always_comb begin
        grantValid = enable && (request != 2'b00);
        grantIndex = 1'b0;
        if (request == 2'b11) begin
            grantIndex = preferred;
        end else begin
            grantIndex = request[1];
        end
    end

    // After a grant, the other requester wins the next tie.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            preferred <= 1'b0;
        end else if (grantValid) begin
            preferred <= ~grantIndex;
        end
    end

endmodule

// File: rtl/ssram_port_arbiter.sv
// Arbitrates two burst requesters onto a single SSRAM port (1-cycle read latency).
//
// state | meaning
// IDLE  | waiting for a request; grants unless a write done is pulsing
// BURST | one beat per cycle to the RAM for the granted requester
// DRAIN | last read word returns from the RAM; done pulses here
module ssram_port_arbiter
    import jtag_ssram_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int BURST_WIDTH = DEFAULT_BURST_WIDTH
) (
    input  logic                   clock,
    input  logic                   nReset,
    input  logic                   request0,
    input  logic                   request1,
    input  logic                   write0,
    input  logic                   write1,
    input  logic [ADDR_WIDTH-1:0]  address0,
    input  logic [ADDR_WIDTH-1:0]  address1,
    input  logic [BURST_WIDTH-1:0] burstLength0,
    input  logic [BURST_WIDTH-1:0] burstLength1,
    input  logic [DATA_WIDTH-1:0]  dataIn0,
    input  logic [DATA_WIDTH-1:0]  dataIn1,
    output logic                   beatAck0,
    output logic                   beatAck1,
    output logic                   readValid0,
    output logic                   readValid1,
    output logic [DATA_WIDTH-1:0]  dataOut0,
    output logic [DATA_WIDTH-1:0]  dataOut1,
    output logic                   done0,
    output logic                   done1,
    output logic [ADDR_WIDTH-1:0]  ramAddress,
    output logic                   ramWriteEnable,
    output logic [DATA_WIDTH-1:0]  ramDataIn,
    input  logic [DATA_WIDTH-1:0]  ramDataOut
);

    arbState_t              state;
    arbState_t              nextState;
    logic                   owner;
    logic                   latchedWrite;
    logic [ADDR_WIDTH-1:0]  curAddr;
    logic [BURST_WIDTH-1:0] beatCount;
    logic [1:0]             readValidReg;
    logic [1:0]             doneReg;
    logic                   grantValid;
    logic                   grantIndex;
    logic                   grantEnable;
    logic                   inBurst;

    assign inBurst = (state == BURST);
    // A write burst's done pulse lands in IDLE; hold off the next grant for that cycle.
    assign grantEnable = (state == IDLE) && (doneReg == 2'b00);

    ssram_rr_arbiter uArbiter (
        .clock      (clock),
        .nReset     (nReset),
        .request    ({request1, request0}),
        .enable     (grantEnable),
        .grantValid (grantValid),
        .grantIndex (grantIndex)
    );

    always_ff @(posedge clock) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState      = state;
        ramAddress     = '0;
        ramWriteEnable = 1'b0;
        ramDataIn      = '0;
        beatAck0       = 1'b0;
        beatAck1       = 1'b0;
        case (state)
            IDLE: begin
                if (grantValid) begin
                    nextState = BURST;
                end
            end
            BURST: begin
                ramAddress     = curAddr;
                ramWriteEnable = latchedWrite;
                ramDataIn      = owner ? dataIn1 : dataIn0;
                beatAck0       = ~owner;
                beatAck1       = owner;
                if (beatCount == '0) begin
                    nextState = latchedWrite ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            owner        <= 1'b0;
            latchedWrite <= 1'b0;
            curAddr      <= '0;
            beatCount    <= '0;
            readValidReg <= '0;
            doneReg      <= '0;
        end else begin
            readValidReg <= '0;
            doneReg      <= '0;
            if (grantValid) begin
                owner        <= grantIndex;
                latchedWrite <= grantIndex ? write1 : write0;
                curAddr      <= grantIndex ? address1 : address0;
                beatCount    <= grantIndex ? burstLength1 : burstLength0;
            end else if (inBurst) begin
                curAddr <= curAddr + 1'b1;
                if (beatCount != '0) begin
                    beatCount <= beatCount - 1'b1;
                end
                if (!latchedWrite) begin
                    readValidReg[owner] <= 1'b1;
                end
                // Registered with the last beat so a read's done lines up with its final word.
                if (beatCount == '0) begin
                    doneReg[owner] <= 1'b1;
                end
            end
        end
    end

    assign readValid0 = readValidReg[0];
    assign readValid1 = readValidReg[1];
    assign dataOut0   = readValidReg[0] ? ramDataOut : '0;
    assign dataOut1   = readValidReg[1] ? ramDataOut : '0;
    assign done0      = doneReg[0];
    assign done1      = doneReg[1];

endmodule

// File: tb/tb_ssram_port_arbiter.sv
// Directed bench for ssram_port_arbiter with a behavioural 1-cycle-latency SSRAM.
module tb_ssram_port_arbiter;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic [1:0]  request = 2'b00;
    logic [1:0]  write = 2'b00;
    logic [8:0]  address [2];
    logic [3:0]  burstLength [2];
    logic [31:0] dataIn [2];
    wire  [1:0]  beatAck;
    wire  [1:0]  readValid;
    wire  [1:0]  done;
    wire  [31:0] dataOut0;
    wire  [31:0] dataOut1;
    wire  [8:0]  ramAddress;
    wire         ramWriteEnable;
    wire  [31:0] ramDataIn;
    logic [31:0] ramDataOut = '0;
    logic [31:0] mem [512];
    logic [31:0] beatData [16];

    int assertCount = 0;
    int failCount = 0;

    ssram_port_arbiter dut (
        .clock          (clock),
        .nReset         (nReset),
        .request0       (request[0]),
        .request1       (request[1]),
        .write0         (write[0]),
        .write1         (write[1]),
        .address0       (address[0]),
        .address1       (address[1]),
        .burstLength0   (burstLength[0]),
        .burstLength1   (burstLength[1]),
        .dataIn0        (dataIn[0]),
        .dataIn1        (dataIn[1]),
        .beatAck0       (beatAck[0]),
        .beatAck1       (beatAck[1]),
        .readValid0     (readValid[0]),
        .readValid1     (readValid[1]),
        .dataOut0       (dataOut0),
        .dataOut1       (dataOut1),
        .done0          (done[0]),
        .done1          (done[1]),
        .ramAddress     (ramAddress),
        .ramWriteEnable (ramWriteEnable),
        .ramDataIn      (ramDataIn),
        .ramDataOut     (ramDataOut)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ramWriteEnable) mem[ramAddress] <= ramDataIn;
        ramDataOut <= mem[ramAddress];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "/beatAck"}, 32'(beatAck), 32'h0);
        check({tag, "/readValid"}, 32'(readValid), 32'h0);
        check({tag, "/done"}, 32'(done), 32'h0);
        check({tag, "/ramAddress"}, 32'(ramAddress), 32'h0);
        check({tag, "/ramWriteEnable"}, 32'(ramWriteEnable), 32'h0);
        check({tag, "/ramDataIn"}, ramDataIn, 32'h0);
        check({tag, "/dataOut0"}, dataOut0, 32'h0);
        check({tag, "/dataOut1"}, dataOut1, 32'h0);
    endtask

    // Single requester burst; beatData holds write data or expected read words.
    task automatic runBurst(input int who, input logic wr, input logic [8:0] addr, input logic [3:0] len);
        logic [8:0] expAddr;
        logic [1:0] whoMask;
        whoMask = 2'b01 << who;
        request[who] = 1'b1;
        write[who] = wr;
        address[who] = addr;
        burstLength[who] = len;
        tick();
        for (int b = 0; b <= int'(len) + 1; b++) begin
            expAddr = addr + 9'(b);
            if (b <= int'(len)) begin
                check("beatAck", 32'(beatAck), 32'(whoMask));
                check("ramAddress", 32'(ramAddress), 32'(expAddr));
                check("ramWriteEnable", 32'(ramWriteEnable), 32'(wr));
                if (wr) begin
                    dataIn[who] = beatData[b];
                    #1;
                    check("ramDataIn", ramDataIn, beatData[b]);
                end
            end else begin
                check("beatAckEnd", 32'(beatAck), 32'h0);
                check("ramWriteEnableEnd", 32'(ramWriteEnable), 32'h0);
                check("ramAddressEnd", 32'(ramAddress), 32'h0);
                request[who] = 1'b0;
            end
            check("readValid", 32'(readValid), (!wr && b >= 1) ? 32'(whoMask) : 32'h0);
            if (!wr && b >= 1) begin
                check("dataOut", (who == 1) ? dataOut1 : dataOut0, beatData[b-1]);
            end
            check("done", 32'(done), (b == int'(len) + 1) ? 32'(whoMask) : 32'h0);
            tick();
        end
        check("doneAfter", 32'(done), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            address[i] = '0;
            burstLength[i] = '0;
            dataIn[i] = '0;
        end

        // Reset state
        tick();
        tick();
        checkIdleOutputs("reset");
        nReset = 1'b1;
        tick();

        // Requester 0 writes 0xA0..0xA3 at 0x010
        for (int i = 0; i < 4; i++) beatData[i] = 32'hA0 + 32'(i);
        runBurst(0, 1'b1, 9'h010, 4'd3);
        for (int i = 0; i < 4; i++) check("ramWrite", mem[9'h010 + 9'(i)], 32'hA0 + 32'(i));

        // Requester 1 reads them back
        runBurst(1, 1'b0, 9'h010, 4'd3);

        // Simultaneous requests twice: requester 0 then requester 1
        request = 2'b11;
        write = 2'b11;
        address[0] = 9'h020;
        address[1] = 9'h030;
        burstLength[0] = 4'd0;
        burstLength[1] = 4'd0;
        tick();
        check("tieA/beatAck", 32'(beatAck), 32'h1);
        check("tieA/ramAddress", 32'(ramAddress), 32'h020);
        dataIn[0] = 32'h11;
        tick();
        check("tieA/done", 32'(done), 32'h1);
        check("tieA/beatAckDone", 32'(beatAck), 32'h0);
        request = 2'b00;
        tick();
        request = 2'b11;
        tick();
        check("tieB/beatAck", 32'(beatAck), 32'h2);
        check("tieB/ramAddress", 32'(ramAddress), 32'h030);
        dataIn[1] = 32'h22;
        tick();
        check("tieB/done", 32'(done), 32'h2);
        request = 2'b00;
        tick();
        check("tieA/mem", mem[9'h020], 32'h11);
        check("tieB/mem", mem[9'h030], 32'h22);

        // Address wrap 0x1FF -> 0x000
        beatData[0] = 32'h12345678;
        beatData[1] = 32'h87654321;
        runBurst(0, 1'b1, 9'h1FF, 4'd1);
        check("wrap/mem1FF", mem[9'h1FF], 32'h12345678);
        check("wrap/mem000", mem[9'h000], 32'h87654321);

        // Reset during beat 2 of a 4-beat read by requester 0
        request[0] = 1'b1;
        write[0] = 1'b0;
        address[0] = 9'h010;
        burstLength[0] = 4'd3;
        tick();
        tick();
        tick();
        check("abort/beat2Ack", 32'(beatAck), 32'h1);
        check("abort/beat2Addr", 32'(ramAddress), 32'h012);
        nReset = 1'b0;
        tick();
        checkIdleOutputs("abort");
        nReset = 1'b1;
        request[0] = 1'b0;
        tick();
        check("abort/noDone", 32'(done), 32'h0);
        check("abort/noReadValid", 32'(readValid), 32'h0);
        request = 2'b11;
        write = 2'b11;
        address[0] = 9'h040;
        address[1] = 9'h041;
        burstLength[0] = 4'd0;
        burstLength[1] = 4'd0;
        tick();
        check("abort/rrPointer", 32'(beatAck), 32'h1);
        dataIn[0] = 32'h55;
        tick();
        check("abort/done", 32'(done), 32'h1);
        request = 2'b00;
        tick();
        check("abort/mem", mem[9'h040], 32'h55);

        // Single-beat read
        beatData[0] = 32'h12345678;
        runBurst(1, 1'b0, 9'h1FF, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
